dcache_mem_ctrl: RTL and testbench
==================================

Name: dcache_mem_ctrl

Overview:
- Memory-side responder for the data cache's block miss interface.
- Accepts a line fill (read) or line writeback (write) request from the cache and serializes it onto the byte-wide RAM port.
- Returns a completed fill to the cache as a one-cycle `memDataValid` pulse, or acknowledges a writeback with a one-cycle `acceptWrite` pulse.
- Sits between the DCache and the RAM/IO bus arbiter.

Parameters:
BLOCK_WIDTH, 4, log2 of line size in bytes
BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes

Ports:
clkIn  in  1  system clock
resetIn  in  1  synchronous active-high reset
readyIn  in  1  global ready; 0 = stall
miss  in  1  cache requests a line transfer
missAddr  in  [31:BLOCK_WIDTH]  line address of request
readWriteIn  in  1  1 = fill (read RAM), 0 = writeback (write RAM)
writeBackIn  in  BLOCK_SIZE*8  line data to write; byte i at bits [8i+7:8i]
memDataValid  out  1  fill complete, one-cycle pulse
memAddr  out  [31:BLOCK_WIDTH]  line address of the fill or writeback being reported
memDataOut  out  BLOCK_SIZE*8  filled line, byte i at bits [8i+7:8i]
acceptWrite  out  1  writeback complete, one-cycle pulse
ramDataIn  in  8  RAM read byte; 1-cycle latency after ramAddr
ramDataOut  out  8  RAM write byte
ramAddr  out  32  RAM byte address
ramWrite  out  1  1 = write ramDataOut at ramAddr this cycle
busy  out  1  1 whenever state != IDLE

Behaviour:

Reset:
- States: IDLE, READ, WRITE, FILL_DONE, WB_DONE.
- resetIn=1 forces IDLE. memDataValid, acceptWrite, ramWrite, busy = 0; ramAddr = 0; memAddr = 0; memDataOut = 0; ramDataOut = 0; counters = 0.
- Reset mid-transfer discards any partial line and issues no further RAM writes.

IDLE:
- If readyIn=1 and miss=1, latch missAddr, readWriteIn and writeBackIn.
- Next state is READ if readWriteIn=1, WRITE if readWriteIn=0.
- Inputs are ignored after acceptance until the next return to IDLE.
- miss with readyIn=0 is not accepted.
- In IDLE: ramWrite=0, ramAddr=0.

Address and latency conventions:
- Base address is {latched line, BLOCK_WIDTH'b0}. Byte addresses run base+0 .. base+BLOCK_SIZE-1, with no wrap beyond the line.
- Latency is counted from the acceptance cycle (call it cycle 0), assuming no stalls.

READ:
- In cycles 1..16, ramAddr = base+(n-1) and ramWrite=0.
- Each cycle, ramDataIn is captured as the byte for the address issued in the previous ready cycle (a pending-read flag tracks this).
- Byte j is written into memDataOut[8j+7:8j].
- After the 16th byte is captured (cycle 17), go to FILL_DONE.

FILL_DONE:
- Cycle 18: memDataValid=1 and memAddr=latched line for exactly one cycle.
- memDataOut stays stable from this cycle until the next fill begins.
- Next state is IDLE.

WRITE:
- In cycles 1..16, ramWrite=1, ramAddr=base+(n-1), ramDataOut = latched byte n-1.
- After the 16th byte, go to WB_DONE.

WB_DONE:
- Cycle 17: acceptWrite=1 and memAddr=latched line for one cycle.
- Next state is IDLE.

Stall (readyIn=0):
- No state, counter or capture update.
- ramWrite forced 0.
- ramAddr held at its last value, so RAM output keeps presenting the pending byte; the capture on the next ready cycle is therefore still correct.
- A pulse output asserted in a stalled cycle is held until the first ready cycle, then drops.
- Net effect: a stall of k cycles delays completion by exactly k cycles.

Back-to-back requests:
- The earliest re-acceptance is the cycle after a DONE state.
- The cache updates its tag/dirty state on the DONE edge, so a miss sampled in IDLE already reflects that update.
- The writeback-then-fill sequence requires no special handling.

Test Plan:
1. Fill: miss=1, readWriteIn=1, missAddr=0x0000100 (base 0x1000); RAM byte = low 8 bits of address -> ramAddr 0x1000..0x100F in cycles 1..16, ramWrite never 1, memDataValid high only in cycle 18 with memAddr=0x0000100 and memDataOut=0x0F0E...0100.
2. Writeback: readWriteIn=0, missAddr=0x0000020, writeBackIn=0xFFEEDDCCBBAA99887766554433221100 -> ramWrite=1 for 16 cycles at 0x200..0x20F with data 0x00,0x11,...,0xFF, then acceptWrite in cycle 17, busy=0 in cycle 18.
3. Writeback then fill to the same index: miss held and readWriteIn flips 0->1 after acceptWrite -> second request accepted in cycle 18, memDataValid in cycle 36, no idle gap beyond that.
4. Stall: readyIn=0 for cycles 5..7 during a fill -> ramAddr held at 0x1003, no captures, memDataValid in cycle 21, memDataOut identical to scenario 1.
5. Reset in cycle 8 of a writeback -> ramWrite=0 from the next cycle, busy=0, acceptWrite never pulses, next miss accepted normally.
6. Idle with miss=0 or readyIn=0 -> ramWrite=0, memDataValid=0 and acceptWrite=0 for 100 cycles.

Source files
------------

// File: rtl/dcache_mem_ctrl.sv
// dcache_mem_ctrl: serializes data-cache line fills and writebacks onto a byte-wide RAM port.
module dcache_mem_ctrl #(
   parameter int BLOCK_WIDTH = 4,
   parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
   input  logic                      clkIn,
   input  logic                      resetIn,
   input  logic                      readyIn,
   input  logic                      miss,
   input  logic [31:BLOCK_WIDTH]     missAddr,
   input  logic                      readWriteIn,
   input  logic [BLOCK_SIZE*8-1:0]   writeBackIn,
   output logic                      memDataValid,
   output logic [31:BLOCK_WIDTH]     memAddr,
   output logic [BLOCK_SIZE*8-1:0]   memDataOut,
   output logic                      acceptWrite,
   input  logic [7:0]                ramDataIn,
   output logic [7:0]                ramDataOut,
   output logic [31:0]               ramAddr,
   output logic                      ramWrite,
   output logic                      busy
);
   typedef enum logic [2:0] {IDLE, READ, WRITE, FILL_DONE, WB_DONE} state_t;
   localparam logic [BLOCK_WIDTH:0] FULL = (BLOCK_WIDTH + 1)'(BLOCK_SIZE);
   state_t state, next_state;
   logic [BLOCK_WIDTH:0] cnt;
   logic pend;
   logic [31:BLOCK_WIDTH] line;
   logic [BLOCK_SIZE*8-1:0] wb_line, fill_line;
   logic [31:0] issue_addr, held_addr;
   logic [BLOCK_WIDTH-1:0] off, cap_idx;
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (readyIn && miss) next_state = readWriteIn ? READ : WRITE;
         READ:    if (readyIn && pend && cnt == FULL) next_state = FILL_DONE;
         WRITE:   if (readyIn && cnt == FULL - 1'b1) next_state = WB_DONE;
         default: if (readyIn) next_state = IDLE;
      endcase
   end
   // once all bytes are issued the address stays on the last byte of the line
   assign off = cnt[BLOCK_WIDTH] ? '1 : cnt[BLOCK_WIDTH-1:0];
   assign cap_idx = cnt[BLOCK_WIDTH-1:0] - 1'b1;
   assign issue_addr = (state == READ || state == WRITE) ? {line, off} : 32'd0;
   // a stall keeps the pending read's address on the bus so its data is still valid afterwards
   assign ramAddr = readyIn ? issue_addr : held_addr;
   assign ramWrite = readyIn && state == WRITE;
   assign ramDataOut = state == WRITE ? wb_line[{off, 3'b000} +: 8] : 8'd0;
   assign memDataValid = state == FILL_DONE;
   assign acceptWrite = state == WB_DONE;
   assign memAddr = line;
   assign memDataOut = fill_line;
   assign busy = state != IDLE;
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         state     <= IDLE;
         cnt       <= '0;
         pend      <= 1'b0;
         line      <= '0;
         wb_line   <= '0;
         fill_line <= '0;
         held_addr <= '0;
      end else if (readyIn) begin
         state     <= next_state;
         held_addr <= issue_addr;
         if (state == IDLE && miss) begin
            line    <= missAddr;
            wb_line <= writeBackIn;
            cnt     <= '0;
            pend    <= 1'b0;
         end
         if (state == READ && pend) fill_line[{cap_idx, 3'b000} +: 8] <= ramDataIn;
         if (state == READ) pend <= !cnt[BLOCK_WIDTH];
         if ((state == READ && !cnt[BLOCK_WIDTH]) || state == WRITE) cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// tb_dcache_mem_ctrl: vector table, hand sequences and random traffic against a transaction-level model.
module tb_dcache_mem_ctrl;
   localparam int BW = 4;
   logic clk = 1'b0;
   logic rst, ready, miss, rw;
   logic [31:BW] maddr;
   logic [127:0] wdata;
   logic mvalid, awrite, ram_wr, busy;
   logic [31:BW] mem_addr;
   logic [127:0] mdata;
   logic [7:0] rin = 8'd0;
   logic [7:0] rout;
   logic [31:0] raddr;
   logic [7:0] salt = 8'd0;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_mem_ctrl #(.BLOCK_WIDTH(BW)) dut (
      .clkIn(clk), .resetIn(rst), .readyIn(ready), .miss(miss), .missAddr(maddr),
      .readWriteIn(rw), .writeBackIn(wdata), .memDataValid(mvalid), .memAddr(mem_addr),
      .memDataOut(mdata), .acceptWrite(awrite), .ramDataIn(rin), .ramDataOut(rout),
      .ramAddr(raddr), .ramWrite(ram_wr), .busy(busy)
   );

   function automatic logic [7:0] ram_byte(input logic [31:0] a);
      return a[7:0] ^ salt;
   endfunction

   // RAM with one cycle of read latency
   always @(posedge clk) rin <= ram_byte(raddr);

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction model: n is the cycle index since acceptance, advanced only on ready cycles.
   bit active = 0, kind = 0;
   logic [31:BW] m_line;
   logic [127:0] m_wb, m_fill;
   logic [127:0] last_fill = '0;
   logic [31:0] base;
   int n = 0;

   always @(negedge clk) begin
      if (rst) begin
         active = 0;
         last_fill = '0;
      end else if (!active) begin
         chk("idle_busy", busy, 0);
         chk("idle_ram_write", ram_wr, 0);
         chk("idle_valid", mvalid, 0);
         chk("idle_accept", awrite, 0);
         chk("idle_ram_addr", raddr, 0);
         chk("idle_fill_hold", mdata, last_fill);
         if (ready && miss) begin
            active = 1;
            kind = rw;
            m_line = maddr;
            m_wb = wdata;
            n = 1;
            for (int j = 0; j < 16; j++) m_fill[8*j +: 8] = ram_byte({maddr, 4'(j)});
         end
      end else begin
         base = {m_line, 4'h0};
         chk("busy", busy, 1);
         chk("mem_data_valid", mvalid, kind && n == 18);
         chk("accept_write", awrite, !kind && n == 17);
         if (kind && n == 18) begin
            chk("mem_addr", mem_addr, m_line);
            chk("fill_data", mdata, m_fill);
            last_fill = m_fill;
         end
         if (!kind && n == 17) chk("mem_addr", mem_addr, m_line);
         if (!kind) chk("wb_fill_hold", mdata, last_fill);
         chk("ram_write", ram_wr, !kind && ready && n <= 16);
         if (ready && n <= 16) chk("ram_addr", raddr, base + n - 1);
         if (!ready && kind && n >= 2 && n <= 17) chk("stall_ram_addr", raddr, base + n - 2);
         if (!kind && ready && n <= 16) chk("ram_data_out", rout, m_wb[8*(n-1) +: 8]);
         if (ready) begin
            if (n == (kind ? 18 : 17)) active = 0;
            else n++;
         end
      end
   end

   task automatic run_txn(input logic t_rw, input logic [31:BW] t_line, input logic [127:0] t_data,
                          input int sa, input int sl, output int first, output int width);
      first = -1;
      width = 0;
      rw = t_rw;
      maddr = t_line;
      wdata = t_data;
      for (int c = 0; c < 60; c++) begin
         miss = (c == 0);
         ready = !(c >= sa && c < sa + sl);
         #1;
         if (mvalid || awrite) begin
            if (first < 0) first = c;
            width++;
         end else if (first >= 0) break;
         tick();
      end
      miss = 1'b0;
      ready = 1'b1;
   endtask

   typedef struct {
      logic         rw;
      logic [31:BW] line;
      logic [127:0] data;
      int           stall_at;
      int           stall_len;
      int           exp_done;
      int           exp_width;
   } vec_t;
   vec_t vt[7];

   localparam logic [127:0] FILL_0X1000 = 128'h0F0E0D0C0B0A09080706050403020100;
   int first, width, t_aw, t_mv;
   bit saw_accept;

   initial begin
      vt[0] = '{1'b1, 28'h0000100, 128'h0, 0, 0, 18, 1};
      vt[1] = '{1'b0, 28'h0000020, 128'hFFEEDDCCBBAA99887766554433221100, 0, 0, 17, 1};
      vt[2] = '{1'b1, 28'h0000100, 128'h0, 5, 3, 21, 1};
      vt[3] = '{1'b0, 28'h0ABCDE1, 128'h0123456789ABCDEF_FEDCBA9876543210, 1, 2, 19, 1};
      vt[4] = '{1'b1, 28'hFFFFFFF, 128'h0, 17, 4, 22, 1};
      vt[5] = '{1'b1, 28'h0000042, 128'h0, 18, 2, 18, 3};
      vt[6] = '{1'b0, 28'h0000777, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 17, 3, 17, 4};
      rst = 1'b1; ready = 1'b1; miss = 1'b0; rw = 1'b0; maddr = '0; wdata = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_ram_addr", raddr, 0);
      chk("rst_mem_data", mdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ram_data", rout, 0);
      tick();

      for (int i = 0; i < 7; i++) begin
         run_txn(vt[i].rw, vt[i].line, vt[i].data, vt[i].stall_at, vt[i].stall_len, first, width);
         chk("done_cycle", first, vt[i].exp_done);
         chk("pulse_width", width, vt[i].exp_width);
         if (vt[i].line == 28'h0000100) chk("fill_0x1000", mdata, FILL_0X1000);
      end

      // writeback then fill to the same line with miss held throughout
      t_aw = -1;
      t_mv = -1;
      rw = 1'b0; maddr = 28'h0000123; wdata = {$urandom, $urandom, $urandom, $urandom};
      miss = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (awrite) begin
            t_aw = c;
            rw = 1'b1;
         end
         if (mvalid) begin
            t_mv = c;
            break;
         end
         tick();
      end
      miss = 1'b0;
      chk("b2b_accept_cycle", t_aw, 17);
      chk("b2b_valid_cycle", t_mv, 36);
      tick();

      // reset in cycle 8 of a writeback
      rw = 1'b0; maddr = 28'h0000200; wdata = {$urandom, $urandom, $urandom, $urandom};
      miss = 1'b1;
      tick();
      miss = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_mid_ram_write", ram_wr, 0);
      chk("rst_mid_busy", busy, 0);
      saw_accept = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (awrite) saw_accept = 1;
      end
      chk("rst_mid_no_accept", saw_accept, 0);
      run_txn(1'b1, 28'h0000300, 128'h0, 0, 0, first, width);
      chk("post_rst_done_cycle", first, 18);

      // idle with miss=0 or readyIn=0
      for (int c = 0; c < 100; c++) begin
         miss = $urandom_range(0, 1);
         ready = miss ? 1'b0 : 1'($urandom_range(0, 1));
         #1;
         chk("idle_quiet", {ram_wr, mvalid, awrite}, 3'b000);
         tick();
      end
      miss = 1'b0;
      ready = 1'b1;
      tick();

      salt = 8'($urandom);
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         ready = ($urandom_range(0, 7) != 0);
         miss = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         maddr = 28'($urandom);
         wdata = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      rst = 1'b0; ready = 1'b1; miss = 1'b0;
      repeat (40) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
